// File: rtl/instruction_fetch_queue.sv
`timescale 1ns/1ps
// Fetch stage: owns the fetch PC, issues word reads to the L1 I-cache and
// buffers returned instructions in an in-order queue whose head feeds decode.
module instruction_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [24:0] RESET_PC    = 25'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  fetch_operation_in,
  input  logic [24:0] fetch_redirect_pc_in,
  output logic        result_valid_out,
  output logic [24:0] result_program_counter_out,
  output logic [24:0] result_instruction_out,
  output logic        icache_request_valid_out,
  input  logic        icache_request_ready_in,
  output logic [24:0] icache_request_address_out,
  input  logic        icache_response_valid_in,
  input  logic [24:0] icache_response_instruction_in
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW+1:0] DEPTH_LIMIT = (CW+2)'(QUEUE_DEPTH);

  logic [24:0]   r_fetch_pc;
  logic [24:0]   r_q_pc     [QUEUE_DEPTH];
  logic [24:0]   r_q_instr  [QUEUE_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [24:0]   r_out_pc   [QUEUE_DEPTH];
  logic [PW-1:0] r_out_head;
  logic [PW-1:0] r_out_tail;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_count;
  logic          r_res_valid;
  logic [24:0]   r_res_pc;
  logic [24:0]   r_res_instr;

  logic          w_redirect;
  logic          w_dequeue;
  logic [CW+1:0] w_occupancy;
  logic          w_req_valid;
  logic          w_handshake;
  logic          w_resp_drop;
  logic          w_resp_accept;
  logic          w_resp_consumed;
  logic          w_pop;
  logic [PW-1:0] w_next_head;
  logic [24:0]   w_push_pc;

  assign w_redirect  = (fetch_operation_in == 2'd2);
  assign w_dequeue   = (fetch_operation_in == 2'd0);
  assign w_occupancy = {2'b00, r_count} + {2'b00, r_outstanding} + {2'b00, r_drop_count};
  // Gating with rst_in keeps the request low for the whole reset pulse.
  assign w_req_valid = !rst_in && !w_redirect && (w_occupancy < DEPTH_LIMIT);
  assign w_handshake = w_req_valid && icache_request_ready_in;

  assign w_resp_drop     = icache_response_valid_in && (r_drop_count != '0);
  assign w_resp_accept   = icache_response_valid_in && (r_drop_count == '0) &&
                           (r_outstanding != '0) && !w_redirect;
  assign w_resp_consumed = icache_response_valid_in &&
                           ((r_drop_count != '0) || (r_outstanding != '0));
  assign w_pop       = w_dequeue && (r_count != '0);
  assign w_next_head = r_head + PW'(1);
  assign w_push_pc   = r_out_pc[r_out_head];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_fetch_pc    <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_out_head    <= '0;
      r_out_tail    <= '0;
      r_outstanding <= '0;
      r_drop_count  <= '0;
    end else if (w_redirect) begin
      // Every in-flight request becomes a stale response to discard later.
      r_fetch_pc    <= fetch_redirect_pc_in;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_out_head    <= '0;
      r_out_tail    <= '0;
      r_outstanding <= '0;
      r_drop_count  <= r_drop_count + r_outstanding - CW'(w_resp_consumed);
    end else begin
      if (w_handshake) begin
        r_fetch_pc <= r_fetch_pc + 25'd1;
        r_out_tail <= r_out_tail + PW'(1);
      end
      if (w_resp_accept) begin
        r_out_head <= r_out_head + PW'(1);
        r_tail     <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= w_next_head;
      end
      if (w_resp_drop) begin
        r_drop_count <= r_drop_count - CW'(1);
      end
      r_count       <= r_count + CW'(w_resp_accept) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_handshake) - CW'(w_resp_accept);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_handshake) begin
      r_out_pc[r_out_tail] <= r_fetch_pc;
    end
    if (w_resp_accept) begin
      r_q_pc[r_tail]    <= w_push_pc;
      r_q_instr[r_tail] <= icache_response_instruction_in;
    end
  end

  // Result registers track what the queue head will be after this edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_res_valid <= 1'b0;
      r_res_pc    <= '0;
      r_res_instr <= '0;
    end else if (w_redirect) begin
      r_res_valid <= 1'b0;
      r_res_pc    <= '0;
      r_res_instr <= '0;
    end else if (w_pop) begin
      if (r_count == CW'(1)) begin
        r_res_valid <= w_resp_accept;
        if (w_resp_accept) begin
          r_res_pc    <= w_push_pc;
          r_res_instr <= icache_response_instruction_in;
        end
      end else begin
        r_res_valid <= 1'b1;
        r_res_pc    <= r_q_pc[w_next_head];
        r_res_instr <= r_q_instr[w_next_head];
      end
    end else if ((r_count == '0) && w_resp_accept) begin
      r_res_valid <= 1'b1;
      r_res_pc    <= w_push_pc;
      r_res_instr <= icache_response_instruction_in;
    end
  end

  assign result_valid_out           = r_res_valid;
  assign result_program_counter_out = r_res_pc;
  assign result_instruction_out     = r_res_instr;
  assign icache_request_valid_out   = w_req_valid;
  assign icache_request_address_out = r_fetch_pc;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
`timescale 1ns/1ps
// Bench for instruction_fetch_queue: queue-level reference model and an
// in-order I-cache model with adjustable latency, checked every cycle.
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [24:0] START_PC = 25'h10;
  localparam logic [1:0] OP_DEQ   = 2'd0;
  localparam logic [1:0] OP_STALL = 2'd1;
  localparam logic [1:0] OP_REDIR = 2'd2;

  logic        clk = 1'b0;
  logic        rstIn = 1'b1;
  logic [1:0]  opIn = 2'd1;
  logic [24:0] redirectPcIn = '0;
  logic        readyIn = 1'b1;
  logic        respValidIn = 1'b0;
  logic [24:0] respInstrIn = '0;
  logic        resultValid;
  logic [24:0] resultPc;
  logic [24:0] resultInstr;
  logic        reqValid;
  logic [24:0] reqAddr;

  instruction_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(START_PC)) dut (
    .clk_in                         (clk),
    .rst_in                         (rstIn),
    .fetch_operation_in             (opIn),
    .fetch_redirect_pc_in           (redirectPcIn),
    .result_valid_out               (resultValid),
    .result_program_counter_out     (resultPc),
    .result_instruction_out         (resultInstr),
    .icache_request_valid_out       (reqValid),
    .icache_request_ready_in        (readyIn),
    .icache_request_address_out     (reqAddr),
    .icache_response_valid_in       (respValidIn),
    .icache_response_instruction_in (respInstrIn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    int          due;
  } pendT;
  typedef struct {
    logic [24:0] pc;
    logic [24:0] instr;
  } entryT;

  pendT        pend[$];
  entryT       mq[$];
  logic [24:0] mOut[$];
  int          mDrop = 0;
  logic [24:0] mPc = START_PC;
  int          cycleNo = 0;
  int          latency = 1;
  bit          readyRandom = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [24:0] instrOf(input logic [24:0] a);
    return (a ^ 25'h0A5A5A5) + 25'h0001234;
  endfunction

  function automatic bit modelReqValid(input logic [1:0] op);
    return !rstIn && (op != OP_REDIR) && ((mq.size() + mOut.size() + mDrop) < DEPTH);
  endfunction

  task automatic checkEq(input string name, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycleNo);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOut.delete();
    pend.delete();
    mDrop = 0;
    mPc = START_PC;
  endtask

  // Advance the reference model and the cache model across one clock edge.
  task automatic modelUpdate(input logic [1:0] op, input logic [24:0] rpc,
                             input logic ready, input bit resp, input logic [24:0] rinstr);
    bit    hs;
    pendT  p;
    entryT e;
    logic [24:0] tmpPc;
    hs = modelReqValid(op) && ready;
    if (resp) p = pend.pop_front();
    if (hs) begin
      p.addr = mPc;
      p.due  = cycleNo + latency;
      pend.push_back(p);
    end
    if (op == OP_REDIR) begin
      mDrop = mDrop + mOut.size() - ((resp && (mDrop > 0 || mOut.size() > 0)) ? 1 : 0);
      mOut.delete();
      mq.delete();
      mPc = rpc;
    end else begin
      if (op == OP_DEQ && mq.size() > 0) e = mq.pop_front();
      if (resp) begin
        if (mDrop > 0) mDrop--;
        else if (mOut.size() > 0) begin
          tmpPc   = mOut.pop_front();
          e.pc    = tmpPc;
          e.instr = rinstr;
          mq.push_back(e);
        end
      end
      if (hs) begin
        mOut.push_back(mPc);
        mPc = mPc + 25'd1;
      end
    end
  endtask

  task automatic checkOutput();
    bit expValid;
    bit expReq;
    expValid = mq.size() > 0;
    expReq   = modelReqValid(opIn);
    checkEq("result_valid", 25'(resultValid), 25'(expValid));
    if (expValid) begin
      checkEq("result_pc", resultPc, mq[0].pc);
      checkEq("result_instr", resultInstr, mq[0].instr);
    end
    checkEq("req_valid", 25'(reqValid), 25'(expReq));
    if (expReq) checkEq("req_addr", reqAddr, mPc);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [24:0] rpc);
    bit respNow;
    opIn = op;
    redirectPcIn = rpc;
    readyIn = readyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
    respNow = (pend.size() > 0) && (pend[0].due <= cycleNo);
    respValidIn = respNow;
    respInstrIn = respNow ? instrOf(pend[0].addr) : 25'($urandom);
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate(op, rpc, readyIn, respNow, respInstrIn);
    cycleNo++;
    #1;
  endtask

  // Reset is raised between edges so its effect must be immediate.
  task automatic doReset();
    rstIn = 1'b1;
    opIn = OP_STALL;
    respValidIn = 1'b0;
    readyIn = 1'b1;
    redirectPcIn = '0;
    #1;
    checkEq("rst_result_valid", 25'(resultValid), 25'd0);
    checkEq("rst_result_pc", resultPc, 25'd0);
    checkEq("rst_result_instr", resultInstr, 25'd0);
    checkEq("rst_req_valid", 25'(reqValid), 25'd0);
    modelReset();
    @(posedge clk);
    #1;
    rstIn = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!resultValid && n < 40) begin
      applyStimulus(OP_DEQ, 25'h0);
      n++;
    end
    checkEq(name, 25'(resultValid), 25'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [24:0] rpc;
    int          r;

    // Reset fetch: one result per cycle after startup, PCs from 0x10.
    doReset();
    latency = 1;
    checkEq("pinA_first_addr", reqAddr, START_PC);
    applyStimulus(OP_DEQ, '0);
    applyStimulus(OP_DEQ, '0);
    checkEq("pinA_pc0", resultPc, 25'h10);
    checkEq("pinA_instr0", resultInstr, instrOf(25'h10));
    applyStimulus(OP_DEQ, '0);
    checkEq("pinA_pc1", resultPc, 25'h11);
    applyStimulus(OP_DEQ, '0);
    checkEq("pinA_pc2", resultPc, 25'h12);
    for (int i = 0; i < 6; i++) applyStimulus(OP_DEQ, '0);

    // Backpressure: queue fills, requests stop, head is held.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(OP_STALL, '0);
    checkEq("pinB_model_count", 25'(mq.size()), 25'd4);
    checkEq("pinB_head_pc", resultPc, 25'h10);
    checkEq("pinB_req_valid", 25'(reqValid), 25'd0);
    for (int i = 0; i < 12; i++) applyStimulus(OP_DEQ, '0);

    // Redirect with three requests in flight and no response that cycle.
    doReset();
    latency = 4;
    for (int i = 0; i < 3; i++) applyStimulus(OP_STALL, '0);
    checkEq("pinC_model_outstanding", 25'(mOut.size()), 25'd3);
    applyStimulus(OP_REDIR, 25'h200);
    checkEq("pinC_model_drop", 25'(mDrop), 25'd3);
    checkEq("pinC_valid_after", 25'(resultValid), 25'd0);
    waitValid("pinC_wait_valid");
    checkEq("pinC_first_pc", resultPc, 25'h200);
    checkEq("pinC_first_instr", resultInstr, instrOf(25'h200));

    // Redirect coincident with a response and a valid head.
    doReset();
    latency = 1;
    for (int i = 0; i < 5; i++) applyStimulus(OP_DEQ, '0);
    applyStimulus(OP_REDIR, 25'h40);
    checkEq("pinD_model_drop", 25'(mDrop), 25'd0);
    checkEq("pinD_valid_after", 25'(resultValid), 25'd0);
    waitValid("pinD_wait_valid");
    checkEq("pinD_first_pc", resultPc, 25'h40);

    // PC wrap-around at the top of the 25-bit space.
    applyStimulus(OP_REDIR, 25'h1FFFFFE);
    waitValid("pinE_wait_valid");
    checkEq("pinE_pc0", resultPc, 25'h1FFFFFE);
    applyStimulus(OP_DEQ, '0);
    checkEq("pinE_pc1", resultPc, 25'h1FFFFFF);
    applyStimulus(OP_DEQ, '0);
    checkEq("pinE_pc2", resultPc, 25'h0000000);

    // Async reset mid-stream with two entries queued.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(OP_STALL, '0);
    checkEq("pinF_model_count", 25'(mq.size()), 25'd2);
    checkEq("pinF_req_before", 25'(reqValid), 25'd1);
    #2;
    doReset();
    checkEq("pinF_restart_addr", reqAddr, START_PC);
    for (int i = 0; i < 6; i++) applyStimulus(OP_DEQ, '0);

    // Randomized traffic: ops, cache readiness, latency and redirect targets.
    readyRandom = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) latency = $urandom_range(1, 4);
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 1) rpc = 25'h1FFFFFC + 25'($urandom_range(0, 3));
      else rpc = 25'($urandom);
      if (r < 60) op = OP_DEQ;
      else if (r < 85) op = OP_STALL;
      else if (r < 93) op = OP_REDIR;
      else op = 2'd3;
      applyStimulus(op, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
